// File: rtl/alu_result_queue_pkg.sv
// alu_result_queue_pkg: shared widths, writeback entry type and R0 tag.
// Imported by the result queue, its pointer controller and interface users.
package alu_result_queue_pkg;

    localparam int DEF_BITWIDTH     = 16;
    localparam int DEF_REGADDRWIDTH = 4;

    localparam logic [DEF_REGADDRWIDTH-1:0] R0_TAG = '0;

    typedef struct packed {
        logic [DEF_BITWIDTH-1:0]     data;
        logic [DEF_REGADDRWIDTH-1:0] dest;
    } wb_entry_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// alu_result_queue_if: valid/ready bus carrying a result and its register tag.
// Ports: valid, ready, data[DW], dest[AW]; master drives valid/data/dest.
interface alu_result_queue_if #(
    parameter int DW = 16,
    parameter int AW = 4
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [AW-1:0] dest;

    modport master (
        output valid,
        output data,
        output dest,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  dest,
        output ready
    );

endinterface

// File: rtl/alu_result_queue_fifo_ptr_ctrl.sv
// alu_result_queue_fifo_ptr_ctrl: read/write pointers, count, full/empty, flush.
// Ports: clk, rst_n, flush, push, pop -> rptr, wptr, count, full, empty.
module alu_result_queue_fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] rptr,
    output logic [PW-1:0] wptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rptr  = rptr_q;
    assign wptr  = wptr_q;
    assign count = count_q;

    a_count_max: assert property (
        @(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(empty && do_pop));
    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(full && do_push));

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: buffers ALU results with their tags ahead of writeback.
// Ports: clk, rst_n, Flush, Result (slave bus), WB (master bus), Occupancy.
module alu_result_queue
    import alu_result_queue_pkg::*;
#(
    parameter int BITWIDTH     = DEF_BITWIDTH,
    parameter int REGADDRWIDTH = DEF_REGADDRWIDTH,
    parameter int DEPTH        = 4,
    parameter bit DROP_R0      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Flush,
    alu_result_queue_if.slave        Result,
    alu_result_queue_if.master       WB,
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int PW = $clog2(DEPTH);

    logic [BITWIDTH-1:0]     data_mem [DEPTH];
    logic [REGADDRWIDTH-1:0] dest_mem [DEPTH];

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;

    assign accept = Result.valid && !full;
    // R0 writes are architecturally void: consume them but never store.
    assign drop   = DROP_R0 &&
                    (Result.dest == REGADDRWIDTH'(R0_TAG));
    assign push   = accept && !drop;
    assign pop    = !empty && WB.ready;

    alu_result_queue_fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (Flush),
        .push  (push),
        .pop   (pop),
        .rptr  (rptr),
        .wptr  (wptr),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (push && !Flush) begin
            data_mem[wptr] <= Result.data;
            dest_mem[wptr] <= Result.dest;
        end
    end

    assign Result.ready = !full;
    assign WB.valid     = !empty;
    // Storage is never reset, so mask the head to zero while empty.
    assign WB.data      = empty ? '0 : data_mem[rptr];
    assign WB.dest      = empty ? '0 : dest_mem[rptr];
    assign Occupancy    = count;

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream neighbour of the simple ALU. Captures each ALU result with its destination register tag and buffers it in a small FIFO.
- Drains to the register-file writeback port over a valid/ready handshake, so ALU issue is not blocked by writeback-port contention.
- Sits between the execute stage's output mux and the register-file writeback arbiter.

Parameters:
- BITWIDTH, 16, result data width; matches the ALU datapath width.
- REGADDRWIDTH, 4, destination register tag width.
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2.
- DROP_R0, 1, when 1, results tagged for register 0 are accepted and discarded, never enqueued.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- Flush  input  1  synchronous queue clear, e.g. on pipeline redirect.
- Result_Valid  input  1  execute stage presents a result this cycle.
- Result_Ready  output  1  queue can accept a result this cycle.
- Result_Data  input  BITWIDTH  ALU ResultOut.
- Result_Dest  input  REGADDRWIDTH  destination register tag.
- WB_Valid  output  1  head entry is valid.
- WB_Ready  input  1  writeback port consumes the head entry this cycle.
- WB_Data  output  BITWIDTH  head entry data.
- WB_Dest  output  REGADDRWIDTH  head entry tag.
- Occupancy  output  $clog2(DEPTH)+1  number of entries currently held.

Behaviour:
- Reset (rst_n low, asynchronous): read pointer, write pointer and count go to 0. Outputs go to WB_Valid=0, Result_Ready=1, Occupancy=0, WB_Data=0, WB_Dest=0. Entry storage is not reset.
- Accept: a result is accepted when Result_Valid && Result_Ready.
- Dequeue: the head entry is dequeued when WB_Valid && WB_Ready.
- Result_Ready = (count != DEPTH). It depends only on registered state; there is no combinational path from WB_Ready.
- When full, no enqueue is allowed even if a dequeue happens in the same cycle.
- Drop: if DROP_R0=1 and Result_Dest==0, an accepted result is consumed but nothing is written and the count does not change.
- Latency: an entry accepted in cycle N is visible on WB_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- WB_Data/WB_Dest come from the storage array at the read pointer. They are valid only while WB_Valid=1 and are held stable until dequeued.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. The full/empty decision uses the separate count register.
- WB_Valid = (count != 0), driven from registered count.
- Flush: takes priority over enqueue and dequeue in the same cycle. Pointers and count go to 0 on the next edge. An accept or handshake in the flush cycle is lost, and the upstream producer must treat it as squashed.
- Reset mid-operation empties the queue immediately, asynchronously.
- Handshake stability: once WB_Valid=1 it stays 1 until dequeued (or until Flush/reset). Upstream may change or withdraw Result_Data freely when Result_Ready=0.
- Assertions: count never exceeds DEPTH; count never goes below 0; no enqueue while full.

Decomposition:
- Shared package: BITWIDTH and REGADDRWIDTH defaults, the writeback entry struct {data, dest}, and the constant R0_TAG=0.
- One natural sub-module: fifo_ptr_ctrl, holding the pointers, count, full/empty logic and flush handling.
- Storage array and drop logic stay in alu_result_queue.

Test Plan:
- Reset and single pass: release rst_n; enqueue Data=0x1234, Dest=3 with WB_Ready=0. Expect WB_Valid=1 next cycle with 0x1234/3 held stable for 5 cycles, Occupancy=1. Raise WB_Ready, then expect WB_Valid=0 and Occupancy=0.
- Fill and back-pressure: with WB_Ready=0, enqueue 0xA001..0xA005 back to back. Expect Result_Ready=0 after the 4th accept and Occupancy=4. The 5th is held off. Drain with WB_Ready=1 and expect order A001, A002, A003, A004, then A005 after it is accepted.
- Streaming: Result_Valid=1 and WB_Ready=1 continuously for 20 cycles with data 0..19. Expect Occupancy to stay at 1, data in order, and one output per cycle after the first.
- Drop R0: enqueue Dest=0 Data=0xFFFF, then Dest=5 Data=0x0042. Expect only 0x0042/5 to appear; Occupancy never exceeds 1. Repeat with DROP_R0=0 and expect both entries.
- Flush collision: with 3 entries queued, assert Flush together with Result_Valid and WB_Ready. Next cycle expect Occupancy=0, WB_Valid=0, and the offered result absent.
- Async reset mid-stream: pull rst_n low mid-cycle with 2 entries queued. Expect WB_Valid=0 and Result_Ready=1 immediately, before the next clock edge.
